multicycle_datapath: RTL and testbench
======================================

Name: multicycle_datapath

Overview:
- Parametrised multicycle successor to the single-cycle ARM-style datapath.
- Fetches and executes over several cycles through one shared memory port with a req/ready handshake; has its own phase sequencer.
- Latches IR, A, B, ALUOut and MDR between phases.
- Decoded control fields come from the existing controller; flags and phase go back to it.

Parameters:
DATA_W, 32, datapath/register/address width
REG_N, 16, register count; index REG_N-1 is the PC alias (R15 at default)
PC_STEP, 1, PC increment per instruction (word-addressed memory)
PC_AHEAD, 2, PC-alias read value = fetch PC + PC_AHEAD

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
regSrc  in  2  [0]: RA1=REG_N-1; [1]: RA2=instr[15:12] else instr[3:0]
regWrite  in  1  write enable for WRITEBACK
immSrc  in  2  extend select
ALUSrc  in  1  ALU B operand: 0=B latch, 1=extImm
ALUControl  in  4  ALU op
memToReg  in  1  WRITEBACK result: 0=ALUOut, 1=MDR
memAccess  in  1  instruction uses MEMORY phase
memWrite  in  1  MEMORY phase is a store
PCSrc  in  1  WRITEBACK loads PC with result
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory completes request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  store strobe (valid with mem_req)
mem_addr  out  DATA_W  request address
mem_wdata  out  DATA_W  store data
instr  out  32  instruction register
phase  out  3  0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEMORY, 4 WRITEBACK
ALUFlags  out  4  NZCV latched in EXECUTE
PC  out  DATA_W  program counter
perf_cycles  out  32  see Optional Feature
perf_instret  out  32  see Optional Feature

Behaviour:
- Reset (reset=0 at clk edge): phase=FETCH, PC=0, instr=0, ALUFlags=0, A/B/ALUOut/MDR=0, registers 0..REG_N-2 = 0. Outputs are registered or decoded from phase, so mem_req=0 during reset.
- Reset mid-request drops mem_req the cycle after the reset edge. The abandoned store is not retried.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Holds until mem_ready=1.
  - On ready: instr<=mem_rdata, fetch_pc<=PC, PC<=PC+PC_STEP, go to DECODE.
- DECODE (1 cycle):
  - A<=reg[RA1], B<=reg[RA2].
  - Reading index REG_N-1 returns fetch_pc+PC_AHEAD.
- EXECUTE (1 cycle):
  - ALUOut and ALUFlags are latched.
  - Next phase is MEMORY if memAccess=1, else WRITEBACK.
- MEMORY:
  - mem_req=1, mem_addr=ALUOut, mem_we=memWrite, mem_wdata=B.
  - Holds until mem_ready=1, then MDR<=mem_rdata.
  - Next phase is FETCH if memWrite=1, else WRITEBACK.
- WRITEBACK (1 cycle):
  - result = memToReg ? MDR : ALUOut.
  - If regWrite and rd=instr[15:12] < REG_N-1: reg[rd]<=result.
  - If PCSrc: PC<=result; this overrides the FETCH increment.
  - A write to REG_N-1 without PCSrc is ignored.
  - Next phase is FETCH.
- Control inputs are sampled only in the phase that uses them. They must be stable from DECODE onward.
- mem_ready while mem_req=0 is ignored. A ready arriving in the same cycle as the request completes it, giving a minimum 1-cycle access.
- ALU ops (DATA_W-bit):
  - 0000 ADD; 0001 SUB (A-B); 0010 AND; 0011 ORR; 0100 EOR; 0101 MOV (B); others give 0.
  - N = msb; Z = result==0.
  - C = carry-out for ADD, NOT borrow for SUB, else 0.
  - V = signed overflow for ADD/SUB, else 0.
- Extend:
  - immSrc 00: zero-extend instr[7:0].
  - 01: zero-extend instr[11:0].
  - 10: sign-extend instr[23:0] (word offset, no shift).
  - 11: 0.
- Latency with zero-wait memory:
  - ALU instruction: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Each wait cycle adds 1.
- PC and address arithmetic wrap modulo 2^DATA_W.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined:
  - perf_cycles increments every cycle after reset.
  - perf_instret increments on each transition into FETCH from WRITEBACK or store-MEMORY.
  - Both are cleared by reset and wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Test Plan:
- Reset, then ready=1 and ADD R1=R0+imm 5 (ALUSrc=1, immSrc=00, regWrite) -> phases 0,1,2,4,0; R1=5; PC=1; next fetch addr=1.
- Load with mem_ready held low 3 cycles in MEMORY, mem_rdata=0xDEADBEEF -> mem_req, mem_addr and mem_we stable throughout; rd=0xDEADBEEF; total 8 cycles.
- Store R2=0x1234 to ALUOut=0x40 -> mem_we=1, mem_addr=0x40, mem_wdata=0x1234; no WRITEBACK; next phase FETCH.
- SUB 0x00000000-1 -> result 0xFFFFFFFF; flags N=1, Z=0, C=0, V=0. SUB 5-5 -> Z=1, C=1.
- Branch at PC=10: RA1=PC alias, imm24=0xFFFFFE, ADD, PCSrc -> A=12, PC=10; write to R15 without PCSrc leaves PC=11.
- Reset asserted during MEMORY wait -> next cycle phase=FETCH, PC=0, mem_req=0. With MC_PERF_CNT_EN: counters 0, then instret=1 after one ALU instruction.

Source files
------------

// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multicycle ARM-style datapath. One instruction runs through FETCH, DECODE,
//   EXECUTE, optional MEMORY and optional WRITEBACK, sharing a single memory
//   port with a req/ready handshake. IR, A, B, ALUOut and MDR hold values
//   between phases.
//
// Optional feature: define MC_PERF_CNT_EN to build the cycle/retire counters;
//   otherwise perf_cycles/perf_instret are tied to zero.
//
// Ports:
//   clk, reset (sync, active-low)
//   regSrc, regWrite, immSrc, ALUSrc, ALUControl, memToReg, memAccess,
//   memWrite, PCSrc          - decoded control fields from the controller
//   mem_rdata, mem_ready     - memory response
//   mem_req, mem_we, mem_addr, mem_wdata - memory request
//   instr, phase, ALUFlags, PC - state back to the controller
//   perf_cycles, perf_instret  - performance counters
module multicycle_datapath #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_N    = 16,
    parameter int unsigned PC_STEP  = 1,
    parameter int unsigned PC_AHEAD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        regSrc,
    input  logic              regWrite,
    input  logic [1:0]        immSrc,
    input  logic              ALUSrc,
    input  logic [3:0]        ALUControl,
    input  logic              memToReg,
    input  logic              memAccess,
    input  logic              memWrite,
    input  logic              PCSrc,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [31:0]       instr,
    output logic [2:0]        phase,
    output logic [3:0]        ALUFlags,
    output logic [DATA_W-1:0] PC,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_instret
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } phase_e;

    phase_e            r_phase, w_phase_next;
    logic              r_run;   // low for the first cycle after reset so mem_req stays 0
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_pc, r_fetch_pc, r_a, r_b, r_aluout, r_mdr;
    logic [3:0]        r_flags;
    logic [DATA_W-1:0] r_regs [REG_N-1];

    logic              w_fetch_done, w_mem_done;
    logic [3:0]        w_ra1, w_ra2, w_rd;
    logic [DATA_W-1:0] w_pc_alias, w_rd1, w_rd2, w_ext, w_srcb, w_alu_res, w_result;
    logic [DATA_W:0]   w_sum, w_diff;
    logic [3:0]        w_alu_flags;
    logic              w_c, w_v;

    // Phase register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase <= StFetch;
            r_run   <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            r_run   <= 1'b1;
        end
    end

    // Next phase and memory port
    always_comb begin
        w_phase_next = r_phase;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = r_pc;
        w_fetch_done = 1'b0;
        w_mem_done   = 1'b0;
        case (r_phase)
            StFetch: begin
                mem_req = r_run;
                if (r_run && mem_ready) begin
                    w_fetch_done = 1'b1;
                    w_phase_next = StDecode;
                end
            end
            StDecode: w_phase_next = StExec;
            StExec:   w_phase_next = memAccess ? StMem : StWb;
            StMem: begin
                mem_req  = 1'b1;
                mem_we   = memWrite;
                mem_addr = r_aluout;
                if (mem_ready) begin
                    w_mem_done   = 1'b1;
                    w_phase_next = memWrite ? StFetch : StWb;
                end
            end
            StWb:     w_phase_next = StFetch;
            default:  w_phase_next = StFetch;
        endcase
    end

    // Register read; the top index aliases the fetch PC plus look-ahead
    always_comb begin
        w_pc_alias = r_fetch_pc + DATA_W'(PC_AHEAD);
        w_ra1      = regSrc[0] ? 4'(REG_N - 1) : r_instr[19:16];
        w_ra2      = regSrc[1] ? r_instr[15:12] : r_instr[3:0];
        w_rd       = r_instr[15:12];
        w_rd1      = '0;
        w_rd2      = '0;
        if (int'(w_ra1) == REG_N - 1)     w_rd1 = w_pc_alias;
        else if (int'(w_ra1) < REG_N - 1) w_rd1 = r_regs[w_ra1];
        if (int'(w_ra2) == REG_N - 1)     w_rd2 = w_pc_alias;
        else if (int'(w_ra2) < REG_N - 1) w_rd2 = r_regs[w_ra2];
    end

    // Immediate extend and ALU
    always_comb begin
        case (immSrc)
            2'b00:   w_ext = DATA_W'(r_instr[7:0]);
            2'b01:   w_ext = DATA_W'(r_instr[11:0]);
            2'b10:   w_ext = {{(DATA_W-24){r_instr[23]}}, r_instr[23:0]};
            default: w_ext = '0;
        endcase
        w_srcb = ALUSrc ? w_ext : r_b;
        w_sum  = {1'b0, r_a} + {1'b0, w_srcb};
        // A + ~B + 1: carry-out is NOT borrow
        w_diff = {1'b0, r_a} + {1'b0, ~w_srcb} + (DATA_W+1)'(1);
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (ALUControl)
            4'b0000: begin
                w_alu_res = w_sum[DATA_W-1:0];
                w_c       = w_sum[DATA_W];
                w_v       = (r_a[DATA_W-1] == w_srcb[DATA_W-1]) &&
                            (w_alu_res[DATA_W-1] != r_a[DATA_W-1]);
            end
            4'b0001: begin
                w_alu_res = w_diff[DATA_W-1:0];
                w_c       = w_diff[DATA_W];
                w_v       = (r_a[DATA_W-1] != w_srcb[DATA_W-1]) &&
                            (w_alu_res[DATA_W-1] != r_a[DATA_W-1]);
            end
            4'b0010: w_alu_res = r_a & w_srcb;
            4'b0011: w_alu_res = r_a | w_srcb;
            4'b0100: w_alu_res = r_a ^ w_srcb;
            4'b0101: w_alu_res = w_srcb;
            default: w_alu_res = '0;
        endcase
        w_alu_flags = {w_alu_res[DATA_W-1], (w_alu_res == '0), w_c, w_v};
        w_result    = memToReg ? r_mdr : r_aluout;
    end

    // Datapath latches and register file
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr    <= '0;
            r_pc       <= '0;
            r_fetch_pc <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_aluout   <= '0;
            r_mdr      <= '0;
            r_flags    <= '0;
            for (int i = 0; i < REG_N - 1; i++) r_regs[i] <= '0;
        end else begin
            if (w_fetch_done) begin
                r_instr    <= mem_rdata[31:0];
                r_fetch_pc <= r_pc;
                r_pc       <= r_pc + DATA_W'(PC_STEP);
            end
            if (r_phase == StDecode) begin
                r_a <= w_rd1;
                r_b <= w_rd2;
            end
            if (r_phase == StExec) begin
                r_aluout <= w_alu_res;
                r_flags  <= w_alu_flags;
            end
            if (w_mem_done) r_mdr <= mem_rdata;
            if (r_phase == StWb) begin
                // Writes to the PC alias index are dropped; only PCSrc moves PC
                if (regWrite && (int'(w_rd) < REG_N - 1)) r_regs[w_rd] <= w_result;
                if (PCSrc) r_pc <= w_result;
            end
        end
    end

`ifdef MC_PERF_CNT_EN
    logic        w_retire;
    logic [31:0] r_perf_cycles, r_perf_instret;

    assign w_retire = (r_phase == StWb) || (w_mem_done && memWrite);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_cycles  <= '0;
            r_perf_instret <= '0;
        end else begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
            if (w_retire) r_perf_instret <= r_perf_instret + 32'd1;
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_instret = r_perf_instret;
`else
    assign perf_cycles  = '0;
    assign perf_instret = '0;
`endif

    assign mem_wdata = r_b;
    assign instr     = r_instr;
    assign phase     = r_phase;
    assign ALUFlags  = r_flags;
    assign PC        = r_pc;

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  regSrc;
    logic        regWrite;
    logic [1:0]  immSrc;
    logic        ALUSrc;
    logic [3:0]  ALUControl;
    logic        memToReg;
    logic        memAccess;
    logic        memWrite;
    logic        PCSrc;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] instr;
    logic [2:0]  phase;
    logic [3:0]  ALUFlags;
    logic [31:0] PC;
    logic [31:0] perf_cycles;
    logic [31:0] perf_instret;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MC_PERF_CNT_EN
    localparam logic [31:0] ExpInstret = 32'd1;
`else
    localparam logic [31:0] ExpInstret = 32'd0;
`endif

    multicycle_datapath dut (
        .clk          (clk),
        .reset        (reset),
        .regSrc       (regSrc),
        .regWrite     (regWrite),
        .immSrc       (immSrc),
        .ALUSrc       (ALUSrc),
        .ALUControl   (ALUControl),
        .memToReg     (memToReg),
        .memAccess    (memAccess),
        .memWrite     (memWrite),
        .PCSrc        (PCSrc),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .instr        (instr),
        .phase        (phase),
        .ALUFlags     (ALUFlags),
        .PC           (PC),
        .perf_cycles  (perf_cycles),
        .perf_instret (perf_instret)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic [1:0] rs, input logic [1:0] is, input logic as,
                            input logic [3:0] ac, input logic rw, input logic m2r,
                            input logic ma, input logic mw, input logic pcs);
        regSrc = rs; immSrc = is; ALUSrc = as; ALUControl = ac; regWrite = rw;
        memToReg = m2r; memAccess = ma; memWrite = mw; PCSrc = pcs;
    endtask

    // Runs one instruction from FETCH with zero-wait memory; returns cycles taken
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] data, output int cyc);
        mem_rdata = ins;
        mem_ready = 1'b1;
        tick();
        cyc = 1;
        mem_rdata = data;
        while (phase !== 3'd0 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        set_ctrl(2'b00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        n_checks++;
        if ({phase, PC, instr, ALUFlags, mem_req} !== {3'd0, 32'd0, 32'd0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got phase=%0d PC=%h instr=%h flags=%b req=%b want 0",
                     phase, PC, instr, ALUFlags, mem_req);
        end
        n_checks++;
        if ({perf_cycles, perf_instret} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_cycles, perf_instret);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_release_fetch: got req=%b we=%b addr=%h want 1 0 0",
                     mem_req, mem_we, mem_addr);
        end
    endtask

    task automatic test_alu;
        // ADD R1 = R0 + 5
        set_ctrl(2'b00, 2'b00, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_rdata = 32'h0000_1005;
        mem_ready = 1'b1;
        tick();
        n_checks++;
        if ({phase, instr, PC} !== {3'd1, 32'h0000_1005, 32'd1}) begin
            n_fail++;
            $display("FAIL alu_decode: got phase=%0d instr=%h PC=%h want 1 00001005 1",
                     phase, instr, PC);
        end
        tick();
        n_checks++;
        if (phase !== 3'd2) begin
            n_fail++;
            $display("FAIL alu_exec_phase: got %0d want 2", phase);
        end
        tick();
        n_checks++;
        if ({phase, ALUFlags} !== {3'd4, 4'b0000}) begin
            n_fail++;
            $display("FAIL alu_wb: got phase=%0d flags=%b want 4 0000", phase, ALUFlags);
        end
        tick();
        n_checks++;
        if ({phase, mem_addr, dut.r_regs[1]} !== {3'd0, 32'd1, 32'd5}) begin
            n_fail++;
            $display("FAIL alu_result: got phase=%0d addr=%h R1=%h want 0 1 5",
                     phase, mem_addr, dut.r_regs[1]);
        end
    endtask

    task automatic test_load_wait;
        int cyc;
        // LDR R3, [R1 + 0x20] -> address 0x25
        set_ctrl(2'b00, 2'b00, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_rdata = 32'h0001_3020;
        mem_ready = 1'b1;
        tick(); cyc = 1;
        mem_ready = 1'b0;
        tick(); cyc++;
        tick(); cyc++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({phase, mem_req, mem_we, mem_addr} !== {3'd3, 1'b1, 1'b0, 32'h25}) begin
                n_fail++;
                $display("FAIL load_wait_%0d: got phase=%0d req=%b we=%b addr=%h want 3 1 0 25",
                         i, phase, mem_req, mem_we, mem_addr);
            end
            tick(); cyc++;
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick(); cyc++;
        n_checks++;
        if (phase !== 3'd4) begin
            n_fail++;
            $display("FAIL load_wb_phase: got %0d want 4", phase);
        end
        tick(); cyc++;
        n_checks++;
        if ({phase, dut.r_regs[3], cyc} !== {3'd0, 32'hDEAD_BEEF, 32'd8}) begin
            n_fail++;
            $display("FAIL load_result: got phase=%0d R3=%h cycles=%0d want 0 deadbeef 8",
                     phase, dut.r_regs[3], cyc);
        end
    endtask

    task automatic test_store;
        int cyc;
        // LDR R2, [R0] with data 0x1234
        set_ctrl(2'b00, 2'b00, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr(32'h0000_2000, 32'h0000_1234, cyc);
        n_checks++;
        if (cyc !== 5) begin
            n_fail++;
            $display("FAIL load_latency: got %0d want 5", cyc);
        end
        // STR R2, [R0 + 0x40]
        set_ctrl(2'b10, 2'b00, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        mem_rdata = 32'h0000_2040;
        mem_ready = 1'b1;
        tick(); cyc = 1;
        mem_ready = 1'b0;
        tick(); cyc++;
        tick(); cyc++;
        n_checks++;
        if ({phase, mem_req, mem_we, mem_addr, mem_wdata} !==
            {3'd3, 1'b1, 1'b1, 32'h40, 32'h1234}) begin
            n_fail++;
            $display("FAIL store_req: got phase=%0d req=%b we=%b addr=%h wdata=%h want 3 1 1 40 1234",
                     phase, mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ready = 1'b1;
        tick(); cyc++;
        n_checks++;
        if ({phase, PC, cyc} !== {3'd0, 32'd4, 32'd4}) begin
            n_fail++;
            $display("FAIL store_done: got phase=%0d PC=%h cycles=%0d want 0 4 4",
                     phase, PC, cyc);
        end
    endtask

    task automatic test_sub_flags;
        int cyc;
        // SUB R4 = R0 - 1
        set_ctrl(2'b00, 2'b00, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0000_4001, 32'd0, cyc);
        n_checks++;
        if ({ALUFlags, dut.r_regs[4], cyc} !== {4'b1000, 32'hFFFF_FFFF, 32'd4}) begin
            n_fail++;
            $display("FAIL sub_neg: got flags=%b R4=%h cycles=%0d want 1000 ffffffff 4",
                     ALUFlags, dut.r_regs[4], cyc);
        end
        // SUB R5 = R1 - 5
        run_instr(32'h0001_5005, 32'd0, cyc);
        n_checks++;
        if ({ALUFlags, dut.r_regs[5]} !== {4'b0110, 32'd0}) begin
            n_fail++;
            $display("FAIL sub_zero: got flags=%b R5=%h want 0110 0", ALUFlags, dut.r_regs[5]);
        end
        // EOR R7 = R3 ^ 0xFF
        set_ctrl(2'b00, 2'b00, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0003_70FF, 32'd0, cyc);
        n_checks++;
        if ({ALUFlags, dut.r_regs[7]} !== {4'b1000, 32'hDEAD_BE10}) begin
            n_fail++;
            $display("FAIL eor: got flags=%b R7=%h want 1000 deadbe10", ALUFlags, dut.r_regs[7]);
        end
    endtask

    task automatic test_branch;
        int cyc;
        // Jump to 10: PC <= R0 + 10
        set_ctrl(2'b00, 2'b00, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr(32'h0000_000A, 32'd0, cyc);
        n_checks++;
        if ({PC, mem_addr} !== {32'd10, 32'd10}) begin
            n_fail++;
            $display("FAIL jump_to_10: got PC=%h addr=%h want a a", PC, mem_addr);
        end
        // B -2 relative to PC alias
        set_ctrl(2'b01, 2'b10, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        mem_rdata = 32'hEAFF_FFFE;
        mem_ready = 1'b1;
        tick();
        n_checks++;
        if (PC !== 32'd11) begin
            n_fail++;
            $display("FAIL branch_fetch_inc: got PC=%h want b", PC);
        end
        tick();
        n_checks++;
        if (dut.r_a !== 32'd12) begin
            n_fail++;
            $display("FAIL branch_pc_alias: got A=%h want c", dut.r_a);
        end
        tick();
        tick();
        n_checks++;
        if ({phase, PC, mem_addr} !== {3'd0, 32'd10, 32'd10}) begin
            n_fail++;
            $display("FAIL branch_target: got phase=%0d PC=%h addr=%h want 0 a a",
                     phase, PC, mem_addr);
        end
        // ADD R15 = R0 + 0x55 without PCSrc
        set_ctrl(2'b00, 2'b00, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0000_F055, 32'd0, cyc);
        n_checks++;
        if ({PC, mem_addr} !== {32'd11, 32'd11}) begin
            n_fail++;
            $display("FAIL r15_write_ignored: got PC=%h addr=%h want b b", PC, mem_addr);
        end
    endtask

    task automatic test_reset_mid_mem;
        int cyc;
        set_ctrl(2'b00, 2'b00, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_rdata = 32'h0000_8000;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if ({phase, mem_req} !== {3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_mem_wait: got phase=%0d req=%b want 3 1", phase, mem_req);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({phase, PC, mem_req, instr, dut.r_regs[1]} !== {3'd0, 32'd0, 1'b0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL mid_mem_reset: got phase=%0d PC=%h req=%b instr=%h R1=%h want 0",
                     phase, PC, mem_req, instr, dut.r_regs[1]);
        end
        n_checks++;
        if ({perf_cycles, perf_instret} !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_mem_perf_clear: got %0d/%0d want 0/0", perf_cycles, perf_instret);
        end
        reset = 1'b1;
        tick();
        set_ctrl(2'b00, 2'b00, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0000_1005, 32'd0, cyc);
        n_checks++;
        if ({perf_instret, dut.r_regs[1], PC} !== {ExpInstret, 32'd5, 32'd1}) begin
            n_fail++;
            $display("FAIL post_reset_instr: got instret=%0d R1=%h PC=%h want %0d 5 1",
                     perf_instret, dut.r_regs[1], PC, ExpInstret);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_store();
        test_sub_flags();
        test_branch();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
